// File: rtl/xoodoo_rc_seq_if.sv
// Handshake bundle between the round-constant sequencer and the round controller.
// The controller drives start/short_i/adv; the sequencer returns constants and status.
interface xoodoo_rc_seq_if #(
  parameter int UNROLL = 1,
  parameter int RC_W   = 32
);
  logic                   start;
  logic                   short_i;
  logic                   adv;
  logic [UNROLL*RC_W-1:0] rc;
  logic                   valid;
  logic                   last;
  logic                   done;
  logic [3:0]             round_idx;

  modport master (
    output start, short_i, adv,
    input  rc, valid, last, done, round_idx
  );

  modport slave (
    input  start, short_i, adv,
    output rc, valid, last, done, round_idx
  );
endinterface

// File: rtl/xoodoo_rc_seq.sv
// Xoodoo round-constant sequencer: UNROLL lanes per cycle over a 12- or 6-round schedule.
// start->valid and final adv->done take 1 cycle; adv=0 stalls indefinitely with outputs held.
module xoodoo_rc_seq #(
  parameter int UNROLL = 1,
  parameter int RC_W   = 32
) (
  input logic            clk,
  input logic            rst,
  xoodoo_rc_seq_if.slave bus
);
  typedef enum logic {IDLE, RUN} state_e;

  localparam logic [5:0] INIT_FULL  = 6'b011_011;
  localparam logic [5:0] INIT_SHORT = 6'b100_011;
  localparam logic [3:0] STEP       = 4'(UNROLL);
  localparam logic [3:0] LAST_FULL  = 4'(12 - UNROLL);
  localparam logic [3:0] LAST_SHORT = 4'(6 - UNROLL);

  generate
    if (UNROLL != 1 && UNROLL != 2 && UNROLL != 3 && UNROLL != 6) begin : g_bad_unroll
      $error("xoodoo_rc_seq: UNROLL must divide 6");
    end
    if (RC_W < 10) begin : g_bad_rc_w
      $error("xoodoo_rc_seq: RC_W must be at least 10");
    end
  endgenerate

  // si' = 3*si mod 7 as si + rotl(si) with end-around carry; qi is a 3-bit LFSR.
  function automatic logic [5:0] rc_step(input logic [5:0] s);
    logic [2:0] q;
    logic [2:0] si;
    logic [2:0] rot;
    logic [3:0] sum;
    q   = s[5:3];
    si  = s[2:0];
    rot = {si[1:0], si[2]};
    sum = {1'b0, si} + {1'b0, rot};
    return {q[1], q[0] ^ q[2], q[2], sum[2:0] + {2'b00, sum[3]}};
  endfunction

  function automatic logic [9:0] rc_lane(input logic [5:0] s);
    logic [9:0] base;
    base = {6'd0, 1'b1, s[5:3]};
    if (s[2:0] == 3'd0 || s[2:0] == 3'd7) return '0;
    return base << s[2:0];
  endfunction

  state_e     state_q, state_d;
  logic [5:0] qs_q, qs_d;
  logic [3:0] idx_q, idx_d;
  logic       short_q, short_d;
  logic       done_q, done_d;
  logic [5:0] qs_adv;
  logic       valid;
  logic       last;

  assign valid         = (state_q == RUN);
  assign last          = valid && (idx_q == (short_q ? LAST_SHORT : LAST_FULL));
  assign bus.valid     = valid;
  assign bus.last      = last;
  assign bus.done      = done_q;
  assign bus.round_idx = idx_q;

  // Lane k sees k chained steps; the state after all lanes is the next group's start.
  always_comb begin
    logic [5:0] s;
    bus.rc = '0;
    s      = qs_q;
    for (int k = 0; k < UNROLL; k++) begin
      if (valid) bus.rc[k*RC_W +: RC_W] = RC_W'(rc_lane(s));
      s = rc_step(s);
    end
    qs_adv = s;
  end

  always_comb begin
    state_d = state_q;
    qs_d    = qs_q;
    idx_d   = idx_q;
    short_d = short_q;
    done_d  = 1'b0;
    if (bus.start) begin
      state_d = RUN;
      qs_d    = bus.short_i ? INIT_SHORT : INIT_FULL;
      idx_d   = '0;
      short_d = bus.short_i;
    end else if (state_q == RUN && bus.adv) begin
      if (last) begin
        state_d = IDLE;
        idx_d   = '0;
        done_d  = 1'b1;
      end else begin
        qs_d  = qs_adv;
        idx_d = idx_q + STEP;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      qs_q    <= '0;
      idx_q   <= '0;
      short_q <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      qs_q    <= qs_d;
      idx_q   <= idx_d;
      short_q <= short_d;
      done_q  <= done_d;
    end
  end
endmodule
